tpu_result_drain: RTL and testbench

- Sits directly downstream of tpu_top on one result write port (a, b or c).
- Captures each full result row that tpu_top writes and buffers it in a small row FIFO.
- Serialises each row into SRAM_DATA_WIDTH-wide beats over a valid/ready stream toward the writeback/DMA path.
- tpu_top cannot stall, so FIFO overflow is detected and flagged, never back-pressured.

---
 rtl/tpu_result_drain_pkg.sv | 40 ++++
 rtl/tpu_result_drain_fifo.sv | 64 ++++++
 rtl/tpu_result_drain.sv | 183 ++++++++++++++++++
 tb/tb_tpu_result_drain.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_result_drain_pkg.sv
// Shared definitions for the TPU result drain: drain FSM states, default widths,
// beat-count/clog2 helpers and the 16-bit clamp limits.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_e;

  localparam int DEF_ARRAY_SIZE        = 32;
  localparam int DEF_OUTPUT_DATA_WIDTH = 32;
  localparam int DEF_SRAM_DATA_WIDTH   = 64;
  localparam int DEF_ADDR_WIDTH        = 6;
  localparam int DEF_FIFO_DEPTH        = 4;

  localparam int CLAMP_MAX = 32767;
  localparam int CLAMP_MIN = -32768;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  function automatic int beats_per_row(input int array_size, input int elem_w, input int beat_w);
    return (array_size * elem_w) / beat_w;
  endfunction

  localparam int DEF_BEATS = beats_per_row(DEF_ARRAY_SIZE, DEF_OUTPUT_DATA_WIDTH, DEF_SRAM_DATA_WIDTH);

endpackage

// File: rtl/tpu_result_drain_fifo.sv
// tpu_row_fifo: synchronous row FIFO with MSB-toggle pointers. A push while full
// is only taken when a pop happens in the same cycle.
module tpu_row_fifo
  import tpu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Status flags and pointer advance
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    rdata = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers; reset discards all buffered rows
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Row storage
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/tpu_result_drain.sv
// Captures tpu_top result rows into a small FIFO and serialises them as beats.
// Optional build macro TPU_DRAIN_CLAMP_EN saturates each element to signed 16 bits on push.
module tpu_result_drain
  import tpu_pkg::*;
#(
  parameter int ARRAY_SIZE        = DEF_ARRAY_SIZE,
  parameter int OUTPUT_DATA_WIDTH = DEF_OUTPUT_DATA_WIDTH,
  parameter int SRAM_DATA_WIDTH   = DEF_SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH        = DEF_FIFO_DEPTH,
  localparam int ROW_W  = ARRAY_SIZE * OUTPUT_DATA_WIDTH,
  localparam int BEATS  = beats_per_row(ARRAY_SIZE, OUTPUT_DATA_WIDTH, SRAM_DATA_WIDTH),
  localparam int BEAT_W = (clog2(BEATS) > 0) ? clog2(BEATS) : 1
) (
  input  logic                       clk,
  input  logic                       srstn,
  input  logic                       tpu_start,
  input  logic                       tpu_done,
  input  logic                       in_we,
  input  logic [ADDR_WIDTH-1:0]      in_waddr,
  input  logic [ROW_W-1:0]           in_wdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SRAM_DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]      out_row_addr,
  output logic [BEAT_W-1:0]          out_beat,
  output logic                       out_last,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  output logic                       drain_done
);

  localparam int FIFO_W = ADDR_WIDTH + ROW_W;

  drain_state_e      state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic              fifo_full, fifo_empty;
  logic              accepting, push_req, pop, handshake, at_last, drop;
  logic [ROW_W-1:0]  row_store;
  logic [FIFO_W-1:0] head;
  logic [BEATS-1:0][SRAM_DATA_WIDTH-1:0] head_beats;

`ifdef TPU_DRAIN_CLAMP_EN
  localparam logic signed [OUTPUT_DATA_WIDTH-1:0] ELEM_MAX = OUTPUT_DATA_WIDTH'(CLAMP_MAX);
  localparam logic signed [OUTPUT_DATA_WIDTH-1:0] ELEM_MIN = OUTPUT_DATA_WIDTH'(CLAMP_MIN);
  logic [ARRAY_SIZE-1:0][OUTPUT_DATA_WIDTH-1:0] in_elems, store_elems;
  logic signed [OUTPUT_DATA_WIDTH-1:0]          elem;

  // Saturate every element into the signed 16-bit range before storage
  always_comb begin
    in_elems    = in_wdata;
    store_elems = in_elems;
    elem        = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      elem = in_elems[i];
      if (elem > ELEM_MAX) begin
        store_elems[i] = ELEM_MAX;
      end else if (elem < ELEM_MIN) begin
        store_elems[i] = ELEM_MIN;
      end else begin
        store_elems[i] = elem;
      end
    end
    row_store = store_elems;
  end
`else
  assign row_store = in_wdata;
`endif

  tpu_row_fifo #(
    .WIDTH(FIFO_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .srstn(srstn),
    .push (push_req),
    .pop  (pop),
    .wdata({in_waddr, row_store}),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Handshake, pop and push/drop qualification; full is judged after the same-cycle pop
  always_comb begin
    accepting = (state_q == RUN) || (state_q == FLUSH);
    handshake = !fifo_empty && out_ready;
    at_last   = (beat_q == BEAT_W'(BEATS - 1));
    pop       = handshake && at_last;
    push_req  = in_we && accepting;
    drop      = push_req && fifo_full && !pop;
  end

  // Next-state, overflow bookkeeping and beat counter
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    beat_d     = beat_q;
    case (state_q)
      IDLE: begin
        if (tpu_start) begin
          state_d    = RUN;
          overflow_d = 1'b0;
          drop_cnt_d = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (tpu_done) begin
          state_d = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (fifo_empty && !handshake) begin
          state_d = DONE;
        end else begin
          state_d = FLUSH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else begin
      drop_cnt_d = drop_cnt_d;
    end
    if (handshake) begin
      beat_d = at_last ? '0 : beat_q + BEAT_W'(1);
    end else begin
      beat_d = beat_q;
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Beat view of the head row; outputs are forced to zero while nothing is buffered
  always_comb begin
    head_beats = head[ROW_W-1:0];
    overflow   = overflow_q;
    drop_cnt   = drop_cnt_q;
    drain_done = (state_q == DONE);
    if (fifo_empty) begin
      out_valid    = 1'b0;
      out_data     = '0;
      out_row_addr = '0;
      out_beat     = '0;
      out_last     = 1'b0;
    end else begin
      out_valid    = 1'b1;
      out_data     = head_beats[beat_q];
      out_row_addr = head[FIFO_W-1:ROW_W];
      out_beat     = beat_q;
      out_last     = at_last;
    end
  end

endmodule

// File: tb/tb_tpu_result_drain.sv
// Randomised scoreboard bench for tpu_result_drain: a phase-level reference model
// predicts accepted rows, drops, flags and drain_done; a monitor checks every beat.
module tb_tpu_result_drain;
  import tpu_pkg::*;

  localparam int AS    = DEF_ARRAY_SIZE;
  localparam int W     = DEF_OUTPUT_DATA_WIDTH;
  localparam int SW    = DEF_SRAM_DATA_WIDTH;
  localparam int AW    = DEF_ADDR_WIDTH;
  localparam int DEPTH = DEF_FIFO_DEPTH;
  localparam int ROW_W = AS * W;
  localparam int BEATS = ROW_W / SW;
  localparam int BW    = (clog2(BEATS) > 0) ? clog2(BEATS) : 1;

  localparam int P_IDLE = 0, P_RUN = 1, P_FLUSH = 2, P_DONE = 3;

  logic             clk, srstn, tpu_start, tpu_done, in_we, out_ready;
  logic [AW-1:0]    in_waddr;
  logic [ROW_W-1:0] in_wdata;
  logic             out_valid, out_last, overflow, drain_done;
  logic [SW-1:0]    out_data;
  logic [AW-1:0]    out_row_addr;
  logic [BW-1:0]    out_beat;
  logic [7:0]       drop_cnt;

  tpu_result_drain dut (
    .clk(clk), .srstn(srstn), .tpu_start(tpu_start), .tpu_done(tpu_done),
    .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row_addr(out_row_addr), .out_beat(out_beat), .out_last(out_last),
    .overflow(overflow), .drop_cnt(drop_cnt), .drain_done(drain_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] data;
    logic [AW-1:0] addr;
    int            beat;
    bit            last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    ready_mode = 0;

  // reference model state: session phase, rows held, beat position, flags
  int ph = P_IDLE, m_cnt = 0, m_beat = 0, m_drops = 0, m_nxt = 0;
  bit m_ovf = 1'b0, m_hs, m_pop;
  logic [ROW_W-1:0] m_row;
  beat_t m_b;

  function automatic logic [ROW_W-1:0] model_store(input logic [ROW_W-1:0] r);
    logic [ROW_W-1:0] s;
    s = r;
`ifdef TPU_DRAIN_CLAMP_EN
    for (int i = 0; i < AS; i++) begin
      logic [W-1:0] e;
      e = r[i*W +: W];
      if ($signed(e) > 32767) e = 32'h00007FFF;
      else if ($signed(e) < -32768) e = 32'hFFFF8000;
      s[i*W +: W] = e;
    end
`endif
    return s;
  endfunction

  // Reference model: judged on the stable pre-edge inputs of each cycle
  always @(negedge clk) begin
    if (!srstn) begin
      ph = P_IDLE; m_cnt = 0; m_beat = 0; m_drops = 0; m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      checks++;
      if (out_valid !== (m_cnt > 0)) begin
        errors++;
        $display("FAIL valid t=%0t got=%b exp=%b", $time, out_valid, (m_cnt > 0));
      end
      checks++;
      if (drain_done !== (ph == P_DONE)) begin
        errors++;
        $display("FAIL drain_done t=%0t got=%b exp=%b", $time, drain_done, (ph == P_DONE));
      end
      checks++;
      if (overflow !== m_ovf || drop_cnt !== 8'(m_drops)) begin
        errors++;
        $display("FAIL ovf_cnt t=%0t got=%b/%0d exp=%b/%0d", $time, overflow, drop_cnt, m_ovf, m_drops);
      end
      m_hs  = (m_cnt > 0) && (out_ready === 1'b1);
      m_pop = m_hs && (m_beat == BEATS - 1);
      m_nxt = ph;
      if (ph == P_IDLE && tpu_start) begin
        m_nxt = P_RUN; m_ovf = 1'b0; m_drops = 0;
      end else if (ph == P_RUN && tpu_done) begin
        m_nxt = P_FLUSH;
      end else if (ph == P_FLUSH && m_cnt == 0 && !m_hs) begin
        m_nxt = P_DONE;
      end else if (ph == P_DONE) begin
        m_nxt = P_IDLE;
      end
      if (in_we && (ph == P_RUN || ph == P_FLUSH)) begin
        if (m_cnt < DEPTH || m_pop) begin
          m_row = model_store(in_wdata);
          for (int k = 0; k < BEATS; k++) begin
            m_b.data = m_row[k*SW +: SW];
            m_b.addr = in_waddr;
            m_b.beat = k;
            m_b.last = (k == BEATS - 1);
            exp_q.push_back(m_b);
          end
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
      if (m_pop) m_cnt--;
      if (m_hs) m_beat = m_pop ? 0 : m_beat + 1;
      ph = m_nxt;
    end
  end

  // Monitor: every handshake pops the scoreboard; stalled outputs must hold
  logic          p_valid = 1'b0, p_ready = 1'b0, p_last;
  logic [SW-1:0] p_data;
  logic [AW-1:0] p_addr;
  logic [BW-1:0] p_beat;
  beat_t         e;
  always @(negedge clk) begin
    if (!srstn) begin
      p_valid = 1'b0;
    end else begin
      if (p_valid && !p_ready) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== p_data || out_row_addr !== p_addr ||
            out_beat !== p_beat || out_last !== p_last) begin
          errors++;
          $display("FAIL stall_hold t=%0t got=%h/%0d exp=%h/%0d", $time, out_data, out_beat, p_data, p_beat);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected t=%0t got addr=%0d beat=%0d", $time, out_row_addr, out_beat);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_row_addr !== e.addr ||
              out_beat !== BW'(e.beat) || out_last !== e.last) begin
            errors++;
            $display("FAIL beat t=%0t got=%h a%0d b%0d l%b exp=%h a%0d b%0d l%b", $time,
                     out_data, out_row_addr, out_beat, out_last, e.data, e.addr, e.beat, e.last);
          end
        end
      end
      p_valid = out_valid; p_ready = out_ready; p_data = out_data;
      p_addr = out_row_addr; p_beat = out_beat; p_last = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      2: out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic start_pulse();
    tpu_start = 1'b1; tick(); tpu_start = 1'b0;
  endtask

  task automatic done_pulse();
    tpu_done = 1'b1; tick(); tpu_done = 1'b0;
  endtask

  task automatic push_row(input logic [AW-1:0] a, input logic [ROW_W-1:0] d);
    in_we = 1'b1; in_waddr = a; in_wdata = d;
    tick();
    in_we = 1'b0;
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i < AS; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  task automatic wait_drain(input int limit);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      if (drain_done === 1'b1) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL drain_timeout t=%0t got=0 exp=1", $time);
    end
    tick();
  endtask

  task automatic wait_beat(input int target, input int limit);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      if (out_valid === 1'b1 && out_beat == BW'(target)) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL beat_timeout t=%0t got=%0d exp=%0d", $time, out_beat, target);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_row_addr !== '0 || out_beat !== '0 ||
        out_last !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0 || drain_done !== 1'b0) begin
      errors++;
      $display("FAIL %s got v=%b d=%h b=%0d ovf=%b cnt=%0d exp all zero", name,
               out_valid, out_data, out_beat, overflow, drop_cnt);
    end
  endtask

  task automatic check_head(input string name, input logic [SW-1:0] d, input logic [AW-1:0] a);
    checks++;
    if (out_valid !== 1'b1 || out_data !== d || out_row_addr !== a || out_beat !== '0) begin
      errors++;
      $display("FAIL %s got v=%b d=%h a=%0d b=%0d exp v=1 d=%h a=%0d b=0", name,
               out_valid, out_data, out_row_addr, out_beat, d, a);
    end
  endtask

  logic [ROW_W-1:0] row;
  logic [SW-1:0]    exp_beat0;

  initial begin
    srstn = 1'b0; tpu_start = 1'b0; tpu_done = 1'b0; in_we = 1'b0;
    in_waddr = '0; in_wdata = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    srstn = 1'b1;
    tick();

    // single ramp row at address 5, full-rate drain
    ready_mode = 1;
    start_pulse();
    for (int i = 0; i < AS; i++) row[i*W +: W] = 32'(i);
    push_row(6'd5, row);
    check_head("single_beat0", 64'h00000001_00000000, 6'd5);
    done_pulse();
    wait_drain(100);

    // alternating backpressure
    ready_mode = 2;
    start_pulse();
    push_row(6'(($urandom_range(0, 63))), rand_row());
    done_pulse();
    wait_drain(200);

    // overflow: five rows into a stalled four-deep FIFO
    ready_mode = 0;
    start_pulse();
    for (int r = 0; r < 5; r++) push_row(6'(r), rand_row());
    idle(3);
    ready_mode = 1;
    done_pulse();
    wait_drain(200);

    // push while full, coinciding with the head row's last-beat handshake
    ready_mode = 0;
    start_pulse();
    for (int r = 0; r < 4; r++) push_row(6'(10 + r), rand_row());
    ready_mode = 1;
    tick();
    wait_beat(BEATS - 1, 40);
    push_row(6'd20, rand_row());
    done_pulse();
    wait_drain(300);

    // flush with two rows buffered
    start_pulse();
    push_row(6'd30, rand_row());
    push_row(6'd31, rand_row());
    done_pulse();
    wait_drain(200);

    // random spacing and random ready, rows also arriving during flush
    ready_mode = 3;
    start_pulse();
    for (int r = 0; r < 30; r++) begin
      push_row(6'($urandom_range(0, 63)), rand_row());
      idle($urandom_range(0, 24));
    end
    done_pulse();
    for (int r = 0; r < 3; r++) begin
      push_row(6'($urandom_range(0, 63)), rand_row());
      idle($urandom_range(0, 4));
    end
    wait_drain(1000);

    // out-of-range elements
    ready_mode = 1;
    start_pulse();
    row = rand_row();
    row[W-1:0]   = 32'h00012345;
    row[2*W-1:W] = 32'hFFFE0000;
`ifdef TPU_DRAIN_CLAMP_EN
    exp_beat0 = 64'hFFFF8000_00007FFF;
`else
    exp_beat0 = 64'hFFFE0000_00012345;
`endif
    push_row(6'd9, row);
    check_head("clamp_beat0", exp_beat0, 6'd9);
    done_pulse();
    wait_drain(100);

    // asynchronous reset in the middle of a row
    start_pulse();
    push_row(6'd3, rand_row());
    push_row(6'd4, rand_row());
    wait_beat(7, 30);
    #2;
    srstn = 1'b0;
    #1;
    check_zero("async_reset");
    tick();
    srstn = 1'b1;
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_beats got=%0d exp=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
